// File: rtl/instr_exec_unit.sv
// Execution stage: one-cycle ALU ops plus an iterative restoring divider for DIV/MOD.
// Results are returned tagged with the source address over a valid/ready output.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no instruction in flight, ready to accept
// S_DIVIDE | restoring divide in progress, RADIX_BITS quotient bits/cycle
// S_DONE   | result held on out_* until the consumer takes it
module instr_exec_unit #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opc,
  input  logic [31:0] in_op_a,
  input  logic [31:0] in_op_b,
  input  logic [4:0]  in_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rez,
  output logic [4:0]  out_addr,
  output logic        out_div_zero,
  output logic        out_illegal,
  output logic        busy
);

  localparam logic [3:0] OPC_ZERO  = 4'd0;
  localparam logic [3:0] OPC_PASSA = 4'd1;
  localparam logic [3:0] OPC_PASSB = 4'd2;
  localparam logic [3:0] OPC_ADD   = 4'd3;
  localparam logic [3:0] OPC_SUB   = 4'd4;
  localparam logic [3:0] OPC_MULT  = 4'd5;
  localparam logic [3:0] OPC_DIV   = 4'd6;
  localparam logic [3:0] OPC_MOD   = 4'd7;

  localparam int         K        = 32 / RADIX_BITS;
  localparam logic [4:0] LAST_CNT = 5'(K - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

  state_t      r_state;
  logic        r_out_valid;
  logic [63:0] r_out_rez;
  logic [4:0]  r_out_addr;
  logic        r_div_zero;
  logic        r_illegal;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [4:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_is_mod;

  logic               w_accept;
  logic               w_is_div;
  logic               w_div_zero;
  logic               w_illegal;
  logic signed [63:0] w_a64;
  logic signed [63:0] w_b64;
  logic [63:0]        w_alu_rez;
  logic [31:0]        w_mag_a;
  logic [31:0]        w_mag_b;
  logic [32:0]        w_rem_nx;
  logic [31:0]        w_quo_nx;
  logic [63:0]        w_q64;
  logic [63:0]        w_r64;
  logic [63:0]        w_rez_q;
  logic [63:0]        w_rez_r;

  assign in_ready     = reset_n && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept     = in_valid && in_ready;
  assign out_valid    = r_out_valid;
  assign out_rez      = r_out_rez;
  assign out_addr     = r_out_addr;
  assign out_div_zero = r_div_zero;
  assign out_illegal  = r_illegal;
  assign busy         = (r_state != S_IDLE);

  assign w_a64      = {{32{in_op_a[31]}}, in_op_a};
  assign w_b64      = {{32{in_op_b[31]}}, in_op_b};
  assign w_is_div   = (in_opc == OPC_DIV) || (in_opc == OPC_MOD);
  assign w_div_zero = w_is_div && (in_op_b == 32'd0);

  // Magnitudes as unsigned: -2^31 maps to 32'h8000_0000, which still fits.
  assign w_mag_a = in_op_a[31] ? (~in_op_a + 32'd1) : in_op_a;
  assign w_mag_b = in_op_b[31] ? (~in_op_b + 32'd1) : in_op_b;

  always_comb begin
    w_alu_rez = '0;
    w_illegal = 1'b0;
    case (in_opc)
      OPC_ZERO:  w_alu_rez = '0;
      OPC_PASSA: w_alu_rez = w_a64;
      OPC_PASSB: w_alu_rez = w_b64;
      OPC_ADD:   w_alu_rez = w_a64 + w_b64;
      OPC_SUB:   w_alu_rez = w_a64 - w_b64;
      OPC_MULT:  w_alu_rez = w_a64 * w_b64;
      OPC_DIV:   w_alu_rez = '0;
      OPC_MOD:   w_alu_rez = '0;
      default:   w_illegal = 1'b1;
    endcase
  end

  // RADIX_BITS restoring steps unrolled per cycle; dividend shifts out of r_quo.
  always_comb begin
    w_rem_nx = {1'b0, r_rem};
    w_quo_nx = r_quo;
    for (int i = 0; i < RADIX_BITS; i++) begin
      w_rem_nx = {w_rem_nx[31:0], w_quo_nx[31]};
      w_quo_nx = {w_quo_nx[30:0], 1'b0};
      if (w_rem_nx >= {1'b0, r_dvs}) begin
        w_rem_nx    = w_rem_nx - {1'b0, r_dvs};
        w_quo_nx[0] = 1'b1;
      end
    end
  end

  assign w_q64   = {32'd0, w_quo_nx};
  assign w_r64   = {32'd0, w_rem_nx[31:0]};
  assign w_rez_q = r_neg_q ? (~w_q64 + 64'd1) : w_q64;
  assign w_rez_r = r_neg_r ? (~w_r64 + 64'd1) : w_r64;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_rez   <= '0;
      r_out_addr  <= '0;
      r_div_zero  <= 1'b0;
      r_illegal   <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_is_mod    <= 1'b0;
    end else if (w_accept) begin
      r_out_addr <= in_addr;
      r_div_zero <= w_div_zero;
      r_illegal  <= w_illegal;
      if (w_is_div && !w_div_zero) begin
        r_state     <= S_DIVIDE;
        r_out_valid <= 1'b0;
        r_rem       <= '0;
        r_quo       <= w_mag_a;
        r_dvs       <= w_mag_b;
        r_cnt       <= '0;
        r_neg_q     <= in_op_a[31] ^ in_op_b[31];
        r_neg_r     <= in_op_a[31];
        r_is_mod    <= (in_opc == OPC_MOD);
      end else begin
        r_state     <= S_DONE;
        r_out_valid <= 1'b1;
        r_out_rez   <= w_alu_rez;
      end
    end else begin
      case (r_state)
        S_DIVIDE: begin
          r_rem <= w_rem_nx[31:0];
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LAST_CNT) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_rez   <= r_is_mod ? w_rez_r : w_rez_q;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: three instances (RADIX_BITS 1, 2, 4) share one directed
// stimulus stream; a monitor pops expected results from per-instance queues.
module tb_instr_exec_unit;

  localparam logic [3:0] ZERO = 4'd0, PASSA = 4'd1, PASSB = 4'd2, ADD = 4'd3;
  localparam logic [3:0] SUB = 4'd4, MULT = 4'd5, DIV = 4'd6, MOD = 4'd7;

  typedef struct packed {
    logic [63:0] rez;
    logic [4:0]  addr;
    logic        dz;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  in_opc;
  logic [31:0] in_op_a, in_op_b;
  logic [4:0]  in_addr;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_dz    [3];
  logic        out_ill   [3];
  logic        busy      [3];
  logic [63:0] out_rez   [3];
  logic [4:0]  out_addr  [3];

  exp_t sb0[$], sb1[$], sb2[$];
  int   total = 0, bad = 0, cyc = 0;
  int   kval[3] = '{32, 16, 8};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      instr_exec_unit #(.RADIX_BITS(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[g]), .in_ready(in_ready[g]),
        .in_opc(in_opc), .in_op_a(in_op_a), .in_op_b(in_op_b), .in_addr(in_addr),
        .out_valid(out_valid[g]), .out_ready(out_ready[g]),
        .out_rez(out_rez[g]), .out_addr(out_addr[g]),
        .out_div_zero(out_dz[g]), .out_illegal(out_ill[g]), .busy(busy[g])
      );
    end
  endgenerate

  function automatic logic [63:0] sext(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  task automatic push_exp(input exp_t e);
    sb0.push_back(e);
    sb1.push_back(e);
    sb2.push_back(e);
  endtask

  task automatic pop_exp(input int i, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    case (i)
      0: if (sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
      1: if (sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
      default: if (sb2.size() > 0) begin e = sb2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Monitor: a transfer happens on the next rising edge when valid && ready at the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset_n && out_valid[i] && out_ready[i]) begin
        exp_t e;
        bit   ok;
        pop_exp(i, e, ok);
        if (!ok) begin
          total++;
          bad++;
          $display("FAIL unexpected_result dut%0d got rez=%h exp=none", i, out_rez[i]);
        end else begin
          check("rez", i, out_rez[i], e.rez);
          check("addr", i, 64'(out_addr[i]), 64'(e.addr));
          check("div_zero", i, 64'(out_dz[i]), 64'(e.dz));
          check("illegal", i, 64'(out_ill[i]), 64'(e.ill));
        end
      end
    end
  end

  task automatic issue(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] addr, input logic [63:0] rez, input logic dz, input logic ill);
    exp_t e;
    bit   acc[3];
    int   n;
    e.rez = rez; e.addr = addr; e.dz = dz; e.ill = ill;
    push_exp(e);
    in_opc = opc; in_op_a = a; in_op_b = b; in_addr = addr;
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b1;
    n = 0;
    while ((in_valid[0] || in_valid[1] || in_valid[2]) && n < 200) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) acc[i] = in_valid[i] && in_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (acc[i]) in_valid[i] = 1'b0;
      n++;
    end
    if (in_valid[0] || in_valid[1] || in_valid[2]) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=not_accepted exp=accepted opc=%0d", opc);
      for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] || busy[1] || busy[2]) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy[0] || busy[1] || busy[2]) begin
      total++;
      bad++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
  endtask

  // Call right after issue(): counts edges after the accept edge until out_valid is seen.
  task automatic lat_check(input bit is_div);
    int lat[3];
    bit seen[3];
    int cnt = 0;
    for (int i = 0; i < 3; i++) begin
      seen[i] = out_valid[i];
      lat[i]  = 0;
    end
    while (!(seen[0] && seen[1] && seen[2]) && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      for (int i = 0; i < 3; i++)
        if (!seen[i] && out_valid[i]) begin
          seen[i] = 1'b1;
          lat[i]  = cnt;
        end
    end
    for (int i = 0; i < 3; i++) begin
      if (!seen[i]) lat[i] = -1;
      check("latency", i, 64'(lat[i]), is_div ? 64'(kval[i]) : 64'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_out_valid"}, i, 64'(out_valid[i]), 64'd0);
      check({tag, "_out_rez"}, i, out_rez[i], 64'd0);
      check({tag, "_out_addr"}, i, 64'(out_addr[i]), 64'd0);
      check({tag, "_flags"}, i, 64'({out_dz[i], out_ill[i]}), 64'd0);
      check({tag, "_busy"}, i, 64'(busy[i]), 64'd0);
      check({tag, "_in_ready"}, i, 64'(in_ready[i]), 64'd0);
    end
  endtask

  initial begin
    int          c0;
    int          n;
    logic [31:0] a;

    reset_n = 1'b0;
    in_opc = '0; in_op_a = '0; in_op_b = '0; in_addr = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check("in_ready_after_reset", i, 64'(in_ready[i]), 64'd1);
    @(posedge clk);
    #1;

    // single-cycle arithmetic
    issue(ADD, 32'h7FFF_FFFF, 32'd1, 5'd3, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
    lat_check(1'b0);
    issue(MULT, 32'hFFFF_FFFE, 32'h4000_0000, 5'd4, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
    issue(SUB, 32'h8000_0000, 32'd1, 5'd5, 64'hFFFF_FFFF_7FFF_FFFF, 1'b0, 1'b0);
    issue(MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd6, 64'h3FFF_FFFF_0000_0001, 1'b0, 1'b0);
    issue(ZERO, 32'd5, 32'd9, 5'd7, 64'd0, 1'b0, 1'b0);

    // divide signs and latency
    wait_idle();
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    lat_check(1'b1);
    wait_idle();
    issue(MOD, 32'hFFFF_FFF9, 32'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    lat_check(1'b1);
    wait_idle();
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
    lat_check(1'b1);
    issue(DIV, 32'd100, 32'd7, 5'd11, 64'd14, 1'b0, 1'b0);
    issue(MOD, 32'd100, 32'hFFFF_FFF9, 5'd12, 64'd2, 1'b0, 1'b0);
    issue(DIV, 32'd7, 32'hFFFF_FFFE, 5'd13, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    issue(MOD, 32'h8000_0000, 32'd3, 5'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    issue(DIV, 32'h7FFF_FFFF, 32'd1, 5'd15, 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0);

    // divide-by-zero, illegal opcodes, flag clearing
    wait_idle();
    issue(DIV, 32'd5, 32'd0, 5'd16, 64'd0, 1'b1, 1'b0);
    lat_check(1'b0);
    issue(4'hC, 32'd1, 32'd2, 5'd17, 64'd0, 1'b0, 1'b1);
    lat_check(1'b0);
    issue(ADD, 32'd2, 32'd3, 5'd18, 64'd5, 1'b0, 1'b0);
    issue(MOD, 32'hFFFF_FFFF, 32'd0, 5'd19, 64'd0, 1'b1, 1'b0);
    issue(4'h8, 32'd1, 32'd1, 5'd20, 64'd0, 1'b0, 1'b1);
    issue(PASSA, 32'h8000_0001, 32'd0, 5'd21, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b0);

    // backpressure: results must hold and no new instruction may enter
    wait_idle();
    for (int i = 0; i < 3; i++) out_ready[i] = 1'b0;
    issue(ADD, 32'hFFFF_FFFB, 32'd2, 5'd22, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    in_opc = PASSA; in_op_a = 32'd123; in_addr = 5'd1;
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        check("hold_out_valid", i, 64'(out_valid[i]), 64'd1);
        check("hold_out_rez", i, out_rez[i], 64'hFFFF_FFFF_FFFF_FFFD);
        check("hold_out_addr", i, 64'(out_addr[i]), 64'd22);
        check("hold_in_ready", i, 64'(in_ready[i]), 64'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end

    // back-to-back PASSA stream: 8 accepts in 8 edges
    wait_idle();
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      a = (k % 2 == 1) ? (32'd0 - 32'(k * 1000)) : (32'(k) << 28);
      issue(PASSA, a, 32'hDEAD_BEEF, 5'(k + 24), sext(a), 1'b0, 1'b0);
    end
    check("stream_cycles", 0, 64'(cyc - c0), 64'd8);

    // reset in the middle of a divide
    wait_idle();
    issue(DIV, 32'd100, 32'd7, 5'd30, 64'd14, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("busy_before_reset", 0, 64'(busy[0]), 64'd1);
    reset_n = 1'b0;
    #1;
    sb0.delete();
    sb1.delete();
    sb2.delete();
    check_reset_outputs("mid_div_reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check("in_ready_after_rereset", i, 64'(in_ready[i]), 64'd1);
    issue(PASSB, 32'd7, 32'hFFFF_FFFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    lat_check(1'b0);

    wait_idle();
    n = 0;
    while ((sb0.size() + sb1.size() + sb2.size()) > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("leftover_expected", 0, 64'(sb0.size() + sb1.size() + sb2.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
